int_issue_queue: RTL and testbench
==================================

# int_issue_queue

Eight-entry integer issue queue sitting directly upstream of the two-wide age picker (`Picker8_2`). It accepts up to two dispatched uops per cycle and tracks operand readiness via writeback tag wakeup. It maintains a compact relative age per entry and presents per-entry age and ready-valid vectors to the picker. It then consumes the picker's two grant ids, removing those entries and registering their payloads onto the issue ports.

## Interface
- INTISQ_WIDTH, 3, entry index width; depth is 2**INTISQ_WIDTH = 8, fixed by the picker.
- TAG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque uop payload width, stored and returned unchanged.

- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  clear all entries and issue registers.
- disp_valid[2]  input  1  dispatch slot valid; `disp_valid[1]` implies `disp_valid[0]`.
- disp_payload[2]  input  PAYLOAD_W  uop payload.
- disp_src1_tag[2], disp_src2_tag[2]  input  TAG_W  source tags.
- disp_src1_rdy[2], disp_src2_rdy[2]  input  1  source already available at dispatch.
- disp_ready  output  1  high when at least 2 entries are free.
- wb_valid[2]  input  1  writeback broadcast valid.
- wb_tag[2]  input  TAG_W  writeback destination tag.
- pick_age[8]  output  INTISQ_WIDTH+1  entry age to picker; larger is older.
- pick_valid[8]  output  1  entry valid and both sources ready.
- grant_id_0, grant_id_1  input  INTISQ_WIDTH  picker outputs (oldest, second oldest).
- grant_valid_0, grant_valid_1  input  1  picker grant valids.
- issue_stall  input  1  downstream cannot accept; grants ignored.
- iss_valid[2]  output  1  registered issue valid (slot 0 = older).
- iss_payload[2]  output  PAYLOAD_W  registered issued payload.

## Operation
- Per entry state: valid, payload, src1/src2 tag, src1/src2 rdy, age.
- Age is defined as the number of valid entries younger than this one. The range is 0..7 and the MSB of `pick_age` is always 0. Valid entries never tie.
- `pick_valid[i]` = valid & src1_rdy & src2_rdy. `pick_age[i]` = stored age, driven combinationally from registers. Invalid entries drive age 0.
- **Dispatch** is accepted only when `disp_valid[k]` & `disp_ready` & !flush.
  - Slot 0 takes the lowest-index free entry; slot 1 takes the next-lowest free entry.
  - Free status is evaluated on current state; entries issued this cycle are not reusable until the next cycle.
  - `disp_ready` is computed combinationally from current valid bits: popcount of free entries ≥ 2.
- **Dispatch bypass:** if a dispatched source tag matches any `wb_valid`/`wb_tag` in the same cycle, store rdy = 1.
- **Wakeup:** any valid entry whose unready source tag matches a valid wb tag sets that rdy bit at the edge.
- **Issue:** when !issue_stall & !flush, each `grant_valid_k` clears entry `grant_id_k` and loads `iss_payload[k]` with that payload and `iss_valid[k]` = 1. Non-granted slots load `iss_valid[k]` = 0.
  - Grants naming an invalid entry are a protocol violation; the assertion fires in simulation.
- **issue_stall:** no entry is removed and `iss_valid`/`iss_payload` hold their values. Dispatch and wakeup proceed normally.
- **Age update** at each edge, with R = number removed and A = number allocated:
  - Surviving entry: new age = old age − (number of removed entries with age < old age) + A.
  - New slot 0 entry: age = A − 1.
  - New slot 1 entry: age = 0.
- **flush:** priority over dispatch, wakeup and issue. All valid bits and `iss_valid` are 0 after the edge.
- **reset:** same as flush. Also zeros ages, rdy bits and `iss_payload`.

## Timing
- Output values after reset: `disp_ready` = 1, `pick_valid` = all 0, `pick_age` = all 0, `iss_valid` = 0, `iss_payload` = 0.
- Dispatch at edge t: the entry is visible in `pick_valid` from cycle t+1 if ready.
- The picker is combinational, so a grant in cycle t+1 gives `iss_valid` in cycle t+2. Minimum dispatch-to-issue latency is 2 cycles.
- Wakeup in cycle t: `pick_valid` rises in cycle t+1.
- Dispatch with a bypass-matched tag in cycle t: `pick_valid` is 1 in t+1.
- Issue removal at edge t: the entry is free and `disp_ready` reflects it in cycle t+1.
- No combinational path from grant inputs to `pick_*` or `disp_ready`.

## Test plan
- **Reset, dual dispatch:** reset then dispatch A (rdy, rdy) and B (rdy, rdy) in one cycle.
  - Required: entries 0 and 1 valid with ages 1 and 0, and `pick_valid` = 8'b0000_0011 next cycle.
  - With picker connected: `iss_payload[0]` = A and `iss_payload[1]` = B one cycle later.
- **Fill and full:** dispatch 8 uops with src1 unready (tag 5).
  - Required: `disp_ready` drops to 0 after 7 are held. The 8th is dispatched single-slot while exactly 1 entry is free? Not permitted: since `disp_ready` requires ≥ 2 free, occupancy stops at 7 with ages 6..0.
- **Wakeup:** `wb_valid[0]` = 1 with `wb_tag[0]` = 5.
  - Required: all waiting entries have `pick_valid` = 1 next cycle, and the two oldest issue in age order.
- **Same-cycle bypass:** dispatch src2_tag = 9 (unready) while `wb_tag[1]` = 9.
  - Required: `pick_valid` = 1 in the following cycle.
- **Age compaction:** with 5 entries of ages 4..0, issue the ages-2 and ages-0 entries while dispatching 1 new uop.
  - Required ages: old 4 → 3, old 3 → 2, old 1 → 1, new → 0.
- **Stall and flush:** with issue_stall = 1 and grants valid, no entries are removed and `iss_*` holds.
  - Then assert flush together with dispatch: all `pick_valid` = 0, `iss_valid` = 0 and `disp_ready` = 1 next cycle.

Source files
------------

// File: rtl/int_issue_queue.sv
// int_issue_queue: 8-entry integer issue queue with tag wakeup, relative ages and two-wide issue.
// Ages count valid younger entries, so the picker sees a dense, tie-free ordering.
module int_issue_queue #(
    parameter int INTISQ_WIDTH = 3,
    parameter int TAG_W        = 6,
    parameter int PAYLOAD_W    = 32,
    localparam int DEPTH       = 2 ** INTISQ_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic [1:0]              disp_valid_i,
    input  logic [PAYLOAD_W-1:0]    disp_payload_i [2],
    input  logic [TAG_W-1:0]        disp_src1_tag_i [2],
    input  logic [TAG_W-1:0]        disp_src2_tag_i [2],
    input  logic [1:0]              disp_src1_rdy_i,
    input  logic [1:0]              disp_src2_rdy_i,
    output logic                    disp_ready_o,
    input  logic [1:0]              wb_valid_i,
    input  logic [TAG_W-1:0]        wb_tag_i [2],
    output logic [INTISQ_WIDTH:0]   pick_age_o [DEPTH],
    output logic [DEPTH-1:0]        pick_valid_o,
    input  logic [INTISQ_WIDTH-1:0] grant_id_0_i,
    input  logic [INTISQ_WIDTH-1:0] grant_id_1_i,
    input  logic                    grant_valid_0_i,
    input  logic                    grant_valid_1_i,
    input  logic                    issue_stall_i,
    output logic [1:0]              iss_valid_o,
    output logic [PAYLOAD_W-1:0]    iss_payload_o [2]
);
    logic [DEPTH-1:0]                   valid_q, valid_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]    payload_q, payload_d;
    logic [DEPTH-1:0][TAG_W-1:0]        s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [DEPTH-1:0][INTISQ_WIDTH-1:0] age_q, age_d;
    logic [1:0]                         iss_valid_q, iss_valid_d;
    logic [1:0][PAYLOAD_W-1:0]          iss_payload_q, iss_payload_d;
    logic [DEPTH-1:0]                   rem;
    logic [INTISQ_WIDTH:0]              n_free;
    logic [INTISQ_WIDTH-1:0]            idx0, idx1, n_alloc;
    logic [1:0]                         acc;
    logic                               has0, has1, go;

    function automatic logic hit(input logic [TAG_W-1:0] t);
        return (wb_valid_i[0] && wb_tag_i[0] == t) || (wb_valid_i[1] && wb_tag_i[1] == t);
    endfunction

    // Free-slot search uses only current state, so entries leaving this cycle stay unusable.
    always_comb begin
        n_free = '0;
        idx0 = '0;
        idx1 = '0;
        has0 = 1'b0;
        has1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) begin
                n_free = n_free + 1'b1;
                if (has0 && !has1) begin
                    idx1 = INTISQ_WIDTH'(i);
                    has1 = 1'b1;
                end
                if (!has0) begin
                    idx0 = INTISQ_WIDTH'(i);
                    has0 = 1'b1;
                end
            end
        end
        disp_ready_o = n_free >= (INTISQ_WIDTH+1)'(2);
        acc = disp_valid_i & {2{disp_ready_o && !flush_i}};
        n_alloc = INTISQ_WIDTH'(acc[0]) + INTISQ_WIDTH'(acc[1]);
        go = !issue_stall_i && !flush_i;
        for (int i = 0; i < DEPTH; i++)
            rem[i] = go && valid_q[i] &&
                     ((grant_valid_0_i && grant_id_0_i == INTISQ_WIDTH'(i)) ||
                      (grant_valid_1_i && grant_id_1_i == INTISQ_WIDTH'(i)));
    end

    always_comb begin
        logic [INTISQ_WIDTH-1:0] older;
        logic [INTISQ_WIDTH-1:0] e;
        valid_d = valid_q & ~rem;
        payload_d = payload_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        iss_valid_d = iss_valid_q;
        iss_payload_d = iss_payload_q;
        for (int i = 0; i < DEPTH; i++) begin
            older = '0;
            for (int j = 0; j < DEPTH; j++)
                older = older + INTISQ_WIDTH'(rem[j] && age_q[j] < age_q[i]);
            age_d[i] = age_q[i] - older + n_alloc;
            s1_rdy_d[i] = s1_rdy_q[i] | hit(s1_tag_q[i]);
            s2_rdy_d[i] = s2_rdy_q[i] | hit(s2_tag_q[i]);
        end
        for (int k = 0; k < 2; k++) begin
            e = (k == 1) ? idx1 : idx0;
            if (acc[k]) begin
                valid_d[e] = 1'b1;
                payload_d[e] = disp_payload_i[k];
                s1_tag_d[e] = disp_src1_tag_i[k];
                s2_tag_d[e] = disp_src2_tag_i[k];
                s1_rdy_d[e] = disp_src1_rdy_i[k] | hit(disp_src1_tag_i[k]);
                s2_rdy_d[e] = disp_src2_rdy_i[k] | hit(disp_src2_tag_i[k]);
                age_d[e] = (k == 1) ? '0 : n_alloc - INTISQ_WIDTH'(1);
            end
        end
        if (go) begin
            iss_valid_d = {grant_valid_1_i, grant_valid_0_i};
            if (grant_valid_0_i) iss_payload_d[0] = payload_q[grant_id_0_i];
            if (grant_valid_1_i) iss_payload_d[1] = payload_q[grant_id_1_i];
        end
        if (flush_i) begin
            valid_d = '0;
            iss_valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        payload_q <= payload_d;
        s1_tag_q <= s1_tag_d;
        s2_tag_q <= s2_tag_d;
        if (reset_i) begin
            valid_q <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            age_q <= '0;
            iss_valid_q <= '0;
            iss_payload_q <= '0;
        end else begin
            valid_q <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            age_q <= age_d;
            iss_valid_q <= iss_valid_d;
            iss_payload_q <= iss_payload_d;
        end
    end

    // A grant must always name a live entry; anything else is a picker protocol bug.
    always_ff @(posedge clk_i) begin
        if (!reset_i && go) begin
            assert (!grant_valid_0_i || valid_q[grant_id_0_i]);
            assert (!grant_valid_1_i || valid_q[grant_id_1_i]);
        end
    end

    always_comb begin
        pick_valid_o = valid_q & s1_rdy_q & s2_rdy_q;
        iss_valid_o = iss_valid_q;
        for (int i = 0; i < DEPTH; i++)
            pick_age_o[i] = valid_q[i] ? {1'b0, age_q[i]} : '0;
        for (int k = 0; k < 2; k++)
            iss_payload_o[k] = iss_payload_q[k];
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: random and directed stimulus against a sequence-number reference model.
// Expected per-cycle outputs are queued at drive time and popped by an independent monitor.
module tb_int_issue_queue;
    localparam int W = 3;
    localparam int T = 6;
    localparam int P = 32;
    localparam int D = 8;

    logic         clk;
    logic         rst, fl, stall, gv0, gv1, dr;
    logic [1:0]   dv, s1r, s2r, wbv, iv;
    logic [P-1:0] dp [2];
    logic [P-1:0] ip [2];
    logic [T-1:0] t1 [2];
    logic [T-1:0] t2 [2];
    logic [T-1:0] wbt [2];
    logic [W-1:0] gid0, gid1;
    logic [W:0]   pa [D];
    logic [D-1:0] pv;

    int_issue_queue dut (
        .clk_i(clk), .reset_i(rst), .flush_i(fl),
        .disp_valid_i(dv), .disp_payload_i(dp),
        .disp_src1_tag_i(t1), .disp_src2_tag_i(t2),
        .disp_src1_rdy_i(s1r), .disp_src2_rdy_i(s2r),
        .disp_ready_o(dr), .wb_valid_i(wbv), .wb_tag_i(wbt),
        .pick_age_o(pa), .pick_valid_o(pv),
        .grant_id_0_i(gid0), .grant_id_1_i(gid1),
        .grant_valid_0_i(gv0), .grant_valid_1_i(gv1),
        .issue_stall_i(stall), .iss_valid_o(iv), .iss_payload_o(ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                 dr;
        logic [1:0]           iv;
        logic [P-1:0]         ip0;
        logic [P-1:0]         ip1;
        logic [D-1:0]         pv;
        logic [D-1:0][W:0]    pa;
    } rec_t;

    rec_t         exp_q [$];
    int           checks = 0;
    int           failures = 0;

    bit           mv [D];
    bit           r1 [D];
    bit           r2 [D];
    logic [P-1:0] mp [D];
    logic [T-1:0] m1 [D];
    logic [T-1:0] m2 [D];
    int           mseq [D];
    int           seqn = 0;
    bit           ev [2];
    logic [P-1:0] ep [2];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic bit hit(input logic [T-1:0] t);
        return (wbv[0] && wbt[0] == t) || (wbv[1] && wbt[1] == t);
    endfunction

    function automatic int age_of(input int i);
        int n = 0;
        for (int j = 0; j < D; j++) if (mv[j] && mseq[j] > mseq[i]) n++;
        return n;
    endfunction

    // Reference picker: the two oldest ready entries by dispatch order.
    task automatic pick_oldest();
        int a = -1;
        int b = -1;
        for (int i = 0; i < D; i++)
            if (mv[i] && r1[i] && r2[i]) begin
                if (a < 0 || mseq[i] < mseq[a]) begin
                    b = a;
                    a = i;
                end else if (b < 0 || mseq[i] < mseq[b]) b = i;
            end
        gv0 = a >= 0;
        gv1 = b >= 0;
        gid0 = (a >= 0) ? W'(a) : '0;
        gid1 = (b >= 0) ? W'(b) : '0;
    endtask

    task automatic quiet();
        rst = 0; fl = 0; stall = 0; dv = 0; wbv = 0; gv0 = 0; gv1 = 0;
        s1r = 2'b11; s2r = 2'b11;
    endtask

    task automatic cyc();
        rec_t r;
        int   nf;
        int   e;
        bit   ok;
        if (rst) begin
            for (int i = 0; i < D; i++) begin mv[i] = 0; r1[i] = 0; r2[i] = 0; end
            ev[0] = 0; ev[1] = 0; ep[0] = '0; ep[1] = '0;
        end else if (fl) begin
            for (int i = 0; i < D; i++) mv[i] = 0;
            ev[0] = 0; ev[1] = 0;
        end else begin
            nf = 0;
            for (int i = 0; i < D; i++) if (!mv[i]) nf++;
            ok = nf >= 2;
            if (!stall) begin
                ev[0] = gv0; ev[1] = gv1;
                if (gv0) ep[0] = mp[gid0];
                if (gv1) ep[1] = mp[gid1];
            end
            for (int i = 0; i < D; i++) begin
                if (hit(m1[i])) r1[i] = 1;
                if (hit(m2[i])) r2[i] = 1;
            end
            for (int k = 0; k < 2; k++)
                if (dv[k] && ok) begin
                    e = 0;
                    for (int i = D - 1; i >= 0; i--) if (!mv[i]) e = i;
                    mv[e] = 1; mp[e] = dp[k]; m1[e] = t1[k]; m2[e] = t2[k];
                    r1[e] = s1r[k] | hit(t1[k]);
                    r2[e] = s2r[k] | hit(t2[k]);
                    mseq[e] = seqn++;
                end
            if (!stall) begin
                if (gv0) mv[gid0] = 0;
                if (gv1) mv[gid1] = 0;
            end
        end
        nf = 0;
        for (int i = 0; i < D; i++) begin
            if (!mv[i]) nf++;
            r.pv[i] = mv[i] && r1[i] && r2[i];
            r.pa[i] = mv[i] ? (W+1)'(age_of(i)) : '0;
        end
        r.dr = nf >= 2;
        r.iv = {ev[1], ev[0]};
        r.ip0 = ep[0];
        r.ip1 = ep[1];
        exp_q.push_back(r);
        @(negedge clk);
    endtask

    rec_t            mr;
    logic [D-1:0][W:0] apa;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mr = exp_q.pop_front();
            for (int i = 0; i < D; i++) apa[i] = pa[i];
            chk("disp_ready", 64'(dr), 64'(mr.dr));
            chk("pick_valid", 64'(pv), 64'(mr.pv));
            chk("pick_age", 64'(apa), 64'(mr.pa));
            chk("iss_valid", 64'(iv), 64'(mr.iv));
            if (mr.iv[0]) chk("iss_payload0", 64'(ip[0]), 64'(mr.ip0));
            if (mr.iv[1]) chk("iss_payload1", 64'(ip[1]), 64'(mr.ip1));
        end
    end

    initial begin
        quiet();
        for (int k = 0; k < 2; k++) begin
            dp[k] = '0; t1[k] = '0; t2[k] = '0; wbt[k] = '0;
        end
        gid0 = '0; gid1 = '0;
        rst = 1;
        @(negedge clk);
        cyc();
        cyc();
        quiet();
        dv = 2'b11; dp[0] = 32'hAAAA_0001; dp[1] = 32'hBBBB_0002;
        cyc();
        quiet();
        pick_oldest();
        cyc();
        quiet();
        cyc();
        s1r = 2'b00; t1[0] = 6'd5; t1[1] = 6'd5;
        for (int n = 0; n < 8; n++) begin
            dv = 2'b01;
            dp[0] = P'($urandom);
            cyc();
        end
        quiet();
        wbv = 2'b01; wbt[0] = 6'd5;
        cyc();
        quiet();
        for (int n = 0; n < 2; n++) begin
            pick_oldest();
            cyc();
        end
        quiet();
        dv = 2'b01; s2r = 2'b00; t2[0] = 6'd9; dp[0] = 32'hC0DE_0009;
        wbv = 2'b10; wbt[0] = 6'd0; wbt[1] = 6'd9;
        cyc();
        quiet();
        cyc();
        fl = 1;
        cyc();
        quiet();
        dv = 2'b11;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) dv = 2'b01;
            dp[0] = P'($urandom); dp[1] = P'($urandom);
            cyc();
        end
        dv = 2'b01; dp[0] = 32'hDDDD_0005;
        gv0 = 1; gid0 = 3'd2; gv1 = 1; gid1 = 3'd4;
        cyc();
        quiet();
        cyc();
        pick_oldest();
        stall = 1;
        cyc();
        cyc();
        stall = 0; gv0 = 0; gv1 = 0; fl = 1; dv = 2'b11;
        cyc();
        quiet();
        cyc();
        repeat (2000) begin
            rst = 0;
            fl = ($urandom_range(39) == 0);
            stall = ($urandom_range(4) == 0);
            dv[0] = ($urandom_range(3) != 0);
            dv[1] = dv[0] & 1'($urandom_range(1));
            for (int k = 0; k < 2; k++) begin
                dp[k] = P'($urandom);
                t1[k] = T'($urandom_range(7));
                t2[k] = T'($urandom_range(7));
                s1r[k] = 1'($urandom_range(1));
                s2r[k] = 1'($urandom_range(1));
                wbt[k] = T'($urandom_range(7));
            end
            wbv = 2'($urandom_range(3));
            pick_oldest();
            if ($urandom_range(3) == 0) gv1 = 0;
            if ($urandom_range(7) == 0) begin gv0 = 0; gv1 = 0; end
            cyc();
        end
        quiet();
        cyc();
        cyc();
        @(posedge clk);
        #2;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
